// File: rtl/paicore_rx_packer.sv
// Output packetiser between the PAICORE receive stream and DMA S2MM: holds one beat back so tlast
// can be applied afterwards. Optional statistics counters are enabled by PAICORE_RX_PACKER_STATS_EN.
`default_nettype none

module paicore_rx_packer #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_WIDTH-1:0]  frame_num_max,
    input  logic [CNT_WIDTH-1:0]  timeout_cycles,
    input  logic                  flush,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  pkt_done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);

    // Hold slot (H) and output slot (O)
    logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
    logic                  h_vld_q,  h_vld_d;
    logic                  h_last_q, h_last_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic                  o_vld_q,  o_vld_d;
    logic                  o_last_q, o_last_d;

    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0]  idle_cnt_q, idle_cnt_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  pkt_done_q, pkt_done_d;

    logic                  o_free;
    logic                  accept;
    logic                  m_hs;
    logic                  timeout_hit;
    logic                  move_h;
    logic                  move_last;
    logic                  new_last;
    logic [CNT_WIDTH-1:0]  beat_base;
    logic [CNT_WIDTH-1:0]  beat_inc;

    always_comb begin
        o_free        = !o_vld_q || m_axis_tready;
        s_axis_tready = !rst && !flush_pend_q && (!h_vld_q || o_free);
        accept        = s_axis_tvalid && s_axis_tready;
        m_hs          = o_vld_q && m_axis_tready;
        timeout_hit   = (timeout_cycles != '0) && (idle_cnt_q == timeout_cycles);

        // H leaves when it is already closed, when pushed by a new beat, or when closed by timeout/flush.
        move_h    = h_vld_q && o_free && (h_last_q || accept || timeout_hit || flush_pend_q);
        move_last = h_last_q || (!accept && (timeout_hit || flush_pend_q));

        // A closing beat leaving H restarts the count before the same-edge incoming beat is counted.
        beat_base = (move_h && move_last) ? '0 : beat_cnt_q;
        beat_inc  = beat_base + CNT_WIDTH'(1);
        new_last  = s_axis_tlast || ((frame_num_max != '0) && (beat_inc == frame_num_max));
    end

    // NOTE: every next-state variable takes its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        h_data_d     = h_data_q;
        h_vld_d      = h_vld_q;
        h_last_d     = h_last_q;
        o_data_d     = o_data_q;
        o_vld_d      = o_vld_q;
        o_last_d     = o_last_q;
        beat_cnt_d   = beat_base;
        idle_cnt_d   = idle_cnt_q;
        flush_pend_d = flush_pend_q;
        pkt_done_d   = m_hs && o_last_q;

        if (accept) begin
            h_data_d   = s_axis_tdata;
            h_vld_d    = 1'b1;
            h_last_d   = new_last;
            beat_cnt_d = beat_inc;
        end else if (move_h) begin
            h_vld_d  = 1'b0;
            h_last_d = 1'b0;
        end

        if (move_h) begin
            o_data_d = h_data_q;
            o_vld_d  = 1'b1;
            o_last_d = move_last;
        end else if (m_hs) begin
            o_vld_d  = 1'b0;
            o_last_d = 1'b0;
        end

        if (accept || !h_vld_d) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != '1) begin
            idle_cnt_d = idle_cnt_q + CNT_WIDTH'(1);
        end

        if (flush) begin
            flush_pend_d = 1'b1;
        end else if (flush_pend_q && (!h_vld_q || (move_h && move_last))) begin
            flush_pend_d = 1'b0;
        end
    end

    // NOTE: the data registers are reset too, because m_axis_tdata must read zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_data_q     <= '0;
            h_vld_q      <= 1'b0;
            h_last_q     <= 1'b0;
            o_data_q     <= '0;
            o_vld_q      <= 1'b0;
            o_last_q     <= 1'b0;
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            pkt_done_q   <= 1'b0;
        end else begin
            h_data_q     <= h_data_d;
            h_vld_q      <= h_vld_d;
            h_last_q     <= h_last_d;
            o_data_q     <= o_data_d;
            o_vld_q      <= o_vld_d;
            o_last_q     <= o_last_d;
            beat_cnt_q   <= beat_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            flush_pend_q <= flush_pend_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

    assign m_axis_tvalid = o_vld_q;
    assign m_axis_tdata  = o_data_q;
    assign m_axis_tlast  = o_last_q;
    assign pkt_done      = pkt_done_q;
    assign busy          = h_vld_q || o_vld_q || flush_pend_q;

`ifdef PAICORE_RX_PACKER_STATS_EN
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        if (m_hs) begin
            frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
            if (o_last_q) begin
                pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign pkt_cnt   = pkt_cnt_q;
`else
    assign frame_cnt = '0;
    assign pkt_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_paicore_rx_packer.sv
// Directed bench for paicore_rx_packer: frame limit, timeout, upstream tlast, backpressure, flush
// and mid-packet reset. Statistics expectations follow PAICORE_RX_PACKER_STATS_EN.
`timescale 1ns/1ps

module tb_paicore_rx_packer;

    localparam int DW = 64;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] frame_num_max;
    logic [CW-1:0] timeout_cycles;
    logic          flush;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          pkt_done;
    logic          busy;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] pkt_cnt;

    paicore_rx_packer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_num_max  (frame_num_max),
        .timeout_cycles (timeout_cycles),
        .flush          (flush),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .pkt_done       (pkt_done),
        .busy           (busy),
        .frame_cnt      (frame_cnt),
        .pkt_cnt        (pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit last_ok;

    // Output monitor state, written only by the monitor process
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            pd_cnt = 0;
    int            stab_viol = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_l;

    // Expected stream, written only by the stimulus process
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];
    int            rd = 0;
    int            exp_frames = 0;
    int            exp_pkts = 0;
    bit            bp_en = 1'b0;

    always begin
        @(posedge clk);
        #1;
        m_axis_tready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            got_d.push_back(m_axis_tdata);
            got_l.push_back(m_axis_tlast);
        end
        if (pkt_done) pd_cnt++;
        if (prev_stall && !rst) begin
            if (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l) stab_viol++;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_d     = m_axis_tdata;
        prev_l     = m_axis_tlast;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) begin
            n_pass++;
            last_ok = 1'b1;
        end else begin
            last_ok = 1'b0;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        bit ok = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("send accepted", ok, 1'b1);
    endtask

    task automatic expect_beat(input logic [DW-1:0] d, input logic l);
        exp_d.push_back(d);
        exp_l.push_back(l);
        exp_frames++;
        if (l) exp_pkts++;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 3000; n++) begin
            if (!busy) break;
            step();
        end
        check({tag, " drained"}, busy, 1'b0);
        step();
        step();
    endtask

    task automatic compare(input string tag);
        int n_got = got_d.size() - rd;
        check({tag, " beat count"}, n_got, exp_d.size());
        for (int i = 0; i < exp_d.size() && i < n_got; i++) begin
            check($sformatf("%s beat %0d data", tag, i + 1), got_d[rd + i], exp_d[i]);
            if (!last_ok) break;
            check($sformatf("%s beat %0d tlast", tag, i + 1), got_l[rd + i], exp_l[i]);
            if (!last_ok) break;
        end
        rd = got_d.size();
        exp_d.delete();
        exp_l.delete();
        check({tag, " pkt_done pulses"}, pd_cnt, exp_pkts);
`ifdef PAICORE_RX_PACKER_STATS_EN
        check({tag, " frame_cnt"}, frame_cnt, exp_frames);
        check({tag, " pkt_cnt"}, pkt_cnt, exp_pkts);
`else
        check({tag, " frame_cnt"}, frame_cnt, 0);
        check({tag, " pkt_cnt"}, pkt_cnt, 0);
`endif
    endtask

    initial begin
        logic [DW-1:0] d;
        int n;

        rst            = 1'b1;
        flush          = 1'b0;
        frame_num_max  = '0;
        timeout_cycles = '0;
        s_axis_tvalid  = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tlast   = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst m_tvalid", m_axis_tvalid, 1'b0);
        check("rst m_tlast", m_axis_tlast, 1'b0);
        check("rst m_tdata", m_axis_tdata, 64'h0);
        check("rst s_tready", s_axis_tready, 1'b0);
        check("rst pkt_done", pkt_done, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst frame_cnt", frame_cnt, 0);
        check("rst pkt_cnt", pkt_cnt, 0);
        rst = 1'b0;
        step();
        check("post-rst s_tready", s_axis_tready, 1'b1);

        // Frame limit of 4 over 10 back-to-back beats
        frame_num_max = 4;
        for (int i = 1; i <= 10; i++) begin
            d = 64'hA000_0000_0000_0000 | 64'(i);
            send(d, 1'b0);
            expect_beat(d, (i == 4) || (i == 8) || (i == 10));
        end
        repeat (5) step();
        check("limit beats out before flush", got_d.size() - rd, 9);
        check("limit beat10 held busy", busy, 1'b1);
        check("limit beat10 held not shown", m_axis_tvalid, 1'b0);
        pulse_flush();
        wait_idle("limit");
        compare("limit");

        // Timeout: beat 3 closes 17 cycles after its accept
        frame_num_max  = 0;
        timeout_cycles = 16;
        for (int i = 1; i <= 3; i++) begin
            d = 64'hC000_0000_0000_0000 | 64'(i);
            send(d, 1'b0);
            expect_beat(d, i == 3);
        end
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (m_axis_tvalid && m_axis_tlast) begin
                n = k;
                break;
            end
        end
        check("timeout latency", n, 17);
        step();
        check("timeout pkt_done high", pkt_done, 1'b1);
        step();
        check("timeout pkt_done low", pkt_done, 1'b0);
        wait_idle("timeout");
        compare("timeout");

        // Upstream tlast on beat 2, then frame limit 3 closes overall beat 5
        frame_num_max  = 3;
        timeout_cycles = 0;
        for (int i = 1; i <= 6; i++) begin
            d = 64'hD000_0000_0000_0000 | 64'(i);
            send(d, i == 2);
            expect_beat(d, (i == 2) || (i == 5) || (i == 6));
        end
        repeat (3) step();
        pulse_flush();
        wait_idle("upstream tlast");
        compare("upstream tlast");

        // Accept in the same cycle the timeout expires: accept wins, no tlast on the older beat
        frame_num_max  = 0;
        timeout_cycles = 4;
        send(64'hE000_0000_0000_0001, 1'b0);
        expect_beat(64'hE000_0000_0000_0001, 1'b0);
        repeat (4) step();
        send(64'hE000_0000_0000_0002, 1'b0);
        expect_beat(64'hE000_0000_0000_0002, 1'b1);
        wait_idle("accept vs timeout");
        compare("accept vs timeout");

        // Backpressure: random 30% ready, 1000 beats, tlast every 7th
        frame_num_max  = 7;
        timeout_cycles = 0;
        bp_en          = 1'b1;
        for (int i = 1; i <= 1000; i++) begin
            d = 64'hB000_0000_0000_0000 | 64'(i);
            send(d, 1'b0);
            expect_beat(d, (i % 7 == 0) || (i == 1000));
        end
        pulse_flush();
        bp_en = 1'b0;
        wait_idle("backpressure");
        compare("backpressure");
        check("backpressure stability", stab_viol, 0);

        // Flush with input stalled after 5 beats
        frame_num_max = 0;
        for (int i = 1; i <= 5; i++) begin
            d = 64'hF000_0000_0000_0000 | 64'(i);
            send(d, 1'b0);
            expect_beat(d, i == 5);
        end
        step();
        step();
        pulse_flush();
        check("flush pending s_tready", s_axis_tready, 1'b0);
        check("flush pending busy", busy, 1'b1);
        check("flush pending no output", m_axis_tvalid, 1'b0);
        step();
        check("flush closed tvalid", m_axis_tvalid, 1'b1);
        check("flush closed tlast", m_axis_tlast, 1'b1);
        check("flush closed tdata", m_axis_tdata, 64'hF000_0000_0000_0005);
        check("flush done s_tready", s_axis_tready, 1'b1);
        wait_idle("flush stalled");
        compare("flush stalled");

        // Flush in the same cycle a beat is accepted closes that beat
        flush = 1'b1;
        send(64'h1234_5678_9ABC_DEF0, 1'b0);
        flush = 1'b0;
        expect_beat(64'h1234_5678_9ABC_DEF0, 1'b1);
        step();
        check("flush+accept tlast", m_axis_tvalid && m_axis_tlast, 1'b1);
        wait_idle("flush+accept");
        compare("flush+accept");

        // Flush with empty H: nothing emitted, busy for one cycle only
        pulse_flush();
        check("flush empty busy", busy, 1'b1);
        check("flush empty s_tready", s_axis_tready, 1'b0);
        step();
        check("flush empty busy cleared", busy, 1'b0);
        check("flush empty s_tready back", s_axis_tready, 1'b1);
        check("flush empty no output", m_axis_tvalid, 1'b0);
        step();
        compare("flush empty");

        // Reset mid-packet discards held beats and clears statistics
        send(64'h5555_0000_0000_0001, 1'b0);
        send(64'h5555_0000_0000_0002, 1'b0);
        step();
        rst = 1'b1;
        step();
        check("midrst busy", busy, 1'b0);
        check("midrst m_tvalid", m_axis_tvalid, 1'b0);
        check("midrst frame_cnt", frame_cnt, 0);
        check("midrst pkt_cnt", pkt_cnt, 0);
        rst = 1'b0;
        step();
        check("midrst s_tready", s_axis_tready, 1'b1);
        check("midrst still empty", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
